// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-lane stores, aligned word loads,
// fixed RD_LAT access latency and an error flag for misaligned store byte-enables.
module dmem_responder #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_word;
    logic [1:0]          lat_off;
    logic [3:0]          lat_be;
    logic [31:0]         lat_wdata;
    logic [31:0]         mem [2**ADDR_W];
    logic                accept;
    logic                access;
    logic                store_ok;
    logic                unused_addr;

    // Byte enables must be a naturally aligned byte, half or word at the byte offset.
    function automatic logic store_legal(input logic [3:0] be, input logic [1:0] off);
        case ({be, off})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
            6'b0011_00, 6'b1100_10,
            6'b1111_00: store_legal = 1'b1;
            default:    store_legal = 1'b0;
        endcase
    endfunction

    assign unused_addr = ^{req_addr[31:ADDR_W+2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = reset_n && (state == IDLE);
        rsp_valid = (state == RESP);
    end

    assign accept   = req_ready && req_valid;
    assign access   = (state == BUSY) && (cnt == '0);
    assign store_ok = store_legal(lat_be, lat_off);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= CNT_W'(RD_LAT - 1);
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                if (lat_we) begin
                    rsp_rdata <= '0;
                    rsp_err   <= !store_ok;
                end else begin
                    rsp_rdata <= mem[lat_word];
                    rsp_err   <= 1'b0;
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_err <= 1'b0;
            end
        end
    end

    // Request fields are captured once so the requester may move on after accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_word  <= req_addr[ADDR_W+1:2];
            lat_off   <= req_addr[1:0];
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (access && lat_we && store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[lat_word][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule
